serial_magnitude_comparator: RTL and testbench



---
 rtl/smc_pkg.sv | 24 ++
 rtl/two_bit_comparator.sv | 18 +
 rtl/serial_magnitude_comparator.sv | 145 ++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// Shared types and helpers for serial_magnitude_comparator.
//   state_e      : controller states (idle, comparing, result presented)
//   result_t     : one-hot comparison result {b>a, a>b, a==b}
//   pair_count() : number of 2-bit pairs in an operand of the given width
package smc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCompare = 2'd1,
    StDone    = 2'd2
  } state_e;

  // Bit 0: A == B, bit 1: A > B, bit 2: B > A.
  typedef logic [2:0] result_t;

  localparam result_t RES_EQ  = 3'b001;
  localparam result_t RES_AGB = 3'b010;
  localparam result_t RES_BGA = 3'b100;

  function automatic int unsigned pair_count(input int unsigned width);
    return width / 2;
  endfunction

endpackage

// File: rtl/two_bit_comparator.sv
// Combinational magnitude comparator for one 2-bit unsigned pair.
//   A, B        : 2-bit unsigned operands
//   A_equal_B   : A == B
//   A_greater_B : A > B
//   B_greater_A : B > A
module two_bit_comparator (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic       A_equal_B,
  output logic       A_greater_B,
  output logic       B_greater_A
);

  assign A_equal_B   = (A == B);
  assign A_greater_B = (A > B);
  assign B_greater_A = (B > A);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial MSB-first unsigned magnitude comparator, two bits per clock.
// A single two_bit_comparator examines the top pair of each shift register; the first
// differing pair decides the result.
//
// Build option: define SMC_EARLY_EXIT_EN to leave COMPARE on the first differing pair;
// otherwise every comparison takes WIDTH/2 cycles regardless of data.
//
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : operand handshake, a and b captured on acceptance
//   a, b                : WIDTH-bit unsigned operands
//   out_valid/out_ready : result handshake, result held until accepted
//   a_equal_b, a_greater_b, b_greater_a : one-hot result, all zero when out_valid=0
module serial_magnitude_comparator
  import smc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_equal_b,
  output logic             a_greater_b,
  output logic             b_greater_a
);

  localparam int unsigned Pairs = pair_count(WIDTH);
  localparam int unsigned CntW  = (Pairs > 1) ? $clog2(Pairs) : 1;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_magnitude_comparator: WIDTH must be even and >= 2");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              decided_q, decided_d;
  result_t           dec_res_q, dec_res_d;
  result_t           out_res_q, out_res_d;

  logic    slice_eq, slice_agb, slice_bga;
  logic    decided_now;
  result_t slice_res;
  result_t res_now;
  logic    early_exit;

  two_bit_comparator u_slice (
    .A           (a_sh_q[WIDTH-1 -: 2]),
    .B           (b_sh_q[WIDTH-1 -: 2]),
    .A_equal_B   (slice_eq),
    .A_greater_B (slice_agb),
    .B_greater_A (slice_bga)
  );

  always_comb begin
    slice_res   = slice_agb ? RES_AGB : RES_BGA;
    // An earlier recorded difference always takes precedence over the current pair.
    decided_now = decided_q | ~slice_eq;
    res_now     = decided_q ? dec_res_q : slice_res;
`ifdef SMC_EARLY_EXIT_EN
    early_exit  = ~slice_eq;
`else
    early_exit  = 1'b0;
`endif
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    dec_res_d = dec_res_q;
    out_res_d = out_res_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          cnt_d     = CntW'(Pairs - 1);
          decided_d = 1'b0;
          dec_res_d = '0;
          state_d   = StCompare;
        end
      end
      StCompare: begin
        decided_d = decided_now;
        dec_res_d = decided_now ? res_now : '0;
        if ((cnt_q == '0) || early_exit) begin
          out_res_d = decided_now ? res_now : RES_EQ;
          state_d   = StDone;
        end else begin
          a_sh_d = a_sh_q << 2;
          b_sh_d = b_sh_q << 2;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_res_d = '0;
          state_d   = StIdle;
        end
      end
      default: begin
        out_res_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      dec_res_q <= '0;
      out_res_q <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      dec_res_q <= dec_res_d;
      out_res_q <= out_res_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  // out_res_q is only non-zero in StDone, so the result is zero whenever out_valid is low.
  assign a_equal_b   = out_res_q[0];
  assign a_greater_b = out_res_q[1];
  assign b_greater_a = out_res_q[2];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic       a_equal_b;
  logic       a_greater_b;
  logic       b_greater_a;

  serial_magnitude_comparator #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .a_equal_b   (a_equal_b),
    .a_greater_b (a_greater_b),
    .b_greater_a (b_greater_a)
  );

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_hs = -100;
  int   last_acc = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (out_valid) begin
        if (!prev_valid) rise_cyc = cyc;
        check("result_onehot", $countones({b_greater_a, a_greater_b, a_equal_b}), 1);
        if (out_ready) begin
          last_hs = cyc + 1;
          if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_value", int'({b_greater_a, a_greater_b, a_equal_b}), int'(e.res));
            check("result_latency", rise_cyc - e.acc, e.lat);
          end
        end
      end else begin
        check("result_zero_when_invalid", int'({b_greater_a, a_greater_b, a_equal_b}), 0);
      end
    end
    prev_valid = out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands until accepted; returns one cycle after the accepting edge.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] res,
                       input int lat_const, input int lat_early, input bit push);
    int   waited;
    exp_t e;
    waited   = 0;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      step();
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    e.res = res;
`ifdef SMC_EARLY_EXIT_EN
    e.lat = lat_early;
`else
    e.lat = lat_const;
`endif
    if (push) sb.push_back(e);
    last_acc = cyc + 1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    step();
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    step();
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_results", int'({b_greater_a, a_greater_b, a_equal_b}), 0);
    step();
    rst = 1'b0;
    step();
    check("post_reset_in_ready", int'(in_ready), 1);
    check("post_reset_out_valid", int'(out_valid), 0);

    // Directed vectors: a, b, expected result, constant-time latency, early-exit latency.
    issue(8'hA5, 8'hA5, 3'b001, 4, 4, 1'b1);
    issue(8'h80, 8'h7F, 3'b010, 4, 1, 1'b1);
    issue(8'h12, 8'h13, 3'b100, 4, 4, 1'b1);
    issue(8'h4F, 8'h30, 3'b010, 4, 1, 1'b1); // later pair favours b; first pair must win
    issue(8'h24, 8'h20, 3'b010, 4, 3, 1'b1);
    issue(8'h40, 8'h80, 3'b100, 4, 1, 1'b1);
    drain();

    // Backpressure: result held, new operands refused.
    out_ready = 1'b0;
    issue(8'h03, 8'h01, 3'b010, 4, 4, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("bp_out_valid_seen", int'(out_valid), 1);
    a        = 8'h00;
    b        = 8'hFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_out_valid_held", int'(out_valid), 1);
      check("bp_result_held", int'({b_greater_a, a_greater_b, a_equal_b}), 3'b010);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_in_ready_after_hs", int'(in_ready), 1);
    check("bp_out_valid_after_hs", int'(out_valid), 0);
    drain();

    // Reset mid-operation: no result may ever appear for this pair.
    out_ready = 1'b0;
    issue(8'hFF, 8'h00, 3'b010, 4, 1, 1'b0);
    step();
    rst = 1'b1;
    #1;
    check("rst_async_out_valid", int'(out_valid), 0);
    check("rst_async_results", int'({b_greater_a, a_greater_b, a_equal_b}), 0);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("rst_no_stale_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Back-to-back issue with out_ready held high.
    issue(8'h00, 8'h00, 3'b001, 4, 4, 1'b1);
    issue(8'hFE, 8'hFF, 3'b100, 4, 4, 1'b1);
    check("b2b_accept_after_hs", last_acc - last_hs, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
